// File: rtl/pipeline_ingress_arbiter_if.sv
// ---------------------------------------------------------------------------
// pipeline_ingress_arbiter_if
//
// One AXI-Stream link as it is used around the Nanotube pipeline ingress
// arbiter. The same interface type carries both upstream requester streams
// and the stream towards pipeline port 0.
//
// Signals:
//   tdata  [DATA_W]  beat payload
//   tkeep  [KEEP_W]  byte enables (DATA_W/8)
//   tuser  [USER_W]  sideband; the low bits carry the packet length
//   tlast            last beat of a packet
//   tvalid           producer has a beat
//   tready           consumer accepts the beat
//
// Modports:
//   master - stream producer (drives payload and tvalid, samples tready)
//   slave  - stream consumer (samples payload and tvalid, drives tready)
// ---------------------------------------------------------------------------
interface pipeline_ingress_arbiter_if #(
    parameter int DATA_W = 512,
    parameter int KEEP_W = 64,
    parameter int USER_W = 48
);
    logic [DATA_W-1:0] tdata;
    logic [KEEP_W-1:0] tkeep;
    logic [USER_W-1:0] tuser;
    logic              tlast;
    logic              tvalid;
    logic              tready;

    modport master (
        output tdata, tkeep, tuser, tlast, tvalid,
        input  tready
    );

    modport slave (
        input  tdata, tkeep, tuser, tlast, tvalid,
        output tready
    );
endinterface

// File: rtl/pipeline_ingress_arbiter.sv
// ---------------------------------------------------------------------------
// pipeline_ingress_arbiter
//
// Packet-atomic round-robin arbiter sharing the single Nanotube pipeline
// ingress port between two AXI-Stream requesters (for example a host queue
// and a MAC queue). Once a source is granted it keeps the port until its
// tlast handshake, so beats of different packets never interleave. The
// arbitration decision is registered, which costs one idle cycle between
// packets. The arbiter stores no data: the granted stream is muxed straight
// through and backpressure is forwarded to the granted source.
//
// Ports:
//   ap_clk    in   single clock, rising edge
//   ap_rst    in   synchronous active-high reset
//   s0        slave  requester 0 stream (s0_tdata..s0_tready)
//   s1        slave  requester 1 stream (s1_tdata..s1_tready)
//   m         master stream to pipeline port 0 (m_tdata..m_tready)
//   grant     out  one-hot active grant, 2'b00 when idle (bit0 = s0)
//   pkt_cnt0  out  wrapping count of packets completed from s0
//   pkt_cnt1  out  wrapping count of packets completed from s1
// ---------------------------------------------------------------------------
module pipeline_ingress_arbiter #(
    parameter int DATA_W = 512,
    parameter int KEEP_W = 64,
    parameter int USER_W = 48,
    parameter int CNT_W  = 32
) (
    input  logic                        ap_clk,
    input  logic                        ap_rst,
    pipeline_ingress_arbiter_if.slave   s0,
    pipeline_ingress_arbiter_if.slave   s1,
    pipeline_ingress_arbiter_if.master  m,
    output logic [1:0]                  grant,
    output logic [CNT_W-1:0]            pkt_cnt0,
    output logic [CNT_W-1:0]            pkt_cnt1
);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t             state;
    state_t             state_n;
    logic [1:0]         grant_q;
    logic [1:0]         grant_n;
    // 0 = s0 completed the most recent packet, 1 = s1
    logic               last_grant;
    logic               last_grant_n;
    logic               inc0;
    logic               inc1;

    logic               sel0;
    logic               sel1;
    logic               hs;
    logic [DATA_W-1:0]  mux_tdata;
    logic [KEEP_W-1:0]  mux_tkeep;
    logic [USER_W-1:0]  mux_tuser;
    logic               mux_tlast;
    logic               mux_tvalid;
    logic               s0_ready;
    logic               s1_ready;

    // State register. last_grant resets to s1 so that s0 wins the first tie.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state      <= IDLE;
            grant_q    <= 2'b00;
            last_grant <= 1'b1;
            pkt_cnt0   <= '0;
            pkt_cnt1   <= '0;
        end else begin
            state      <= state_n;
            grant_q    <= grant_n;
            last_grant <= last_grant_n;
            if (inc0) begin
                pkt_cnt0 <= pkt_cnt0 + CNT_W'(1);
            end
            if (inc1) begin
                pkt_cnt1 <= pkt_cnt1 + CNT_W'(1);
            end
        end
    end

    // Next-state logic. The round-robin pointer only moves when a packet
    // completes, which is what makes continuous contention alternate.
    always_comb begin
        state_n      = state;
        grant_n      = grant_q;
        last_grant_n = last_grant;
        inc0         = 1'b0;
        inc1         = 1'b0;
        case (state)
            IDLE: begin
                if (s0.tvalid && s1.tvalid) begin
                    grant_n = last_grant ? 2'b01 : 2'b10;
                    state_n = BUSY;
                end else if (s0.tvalid) begin
                    grant_n = 2'b01;
                    state_n = BUSY;
                end else if (s1.tvalid) begin
                    grant_n = 2'b10;
                    state_n = BUSY;
                end
            end
            BUSY: begin
                if (hs && mux_tlast) begin
                    state_n      = IDLE;
                    grant_n      = 2'b00;
                    last_grant_n = grant_q[1];
                    inc0         = grant_q[0];
                    inc1         = grant_q[1];
                end
            end
            default: begin
                state_n = IDLE;
                grant_n = 2'b00;
            end
        endcase
    end

    // Output mux on the registered grant. Outputs are forced to zero while
    // idle so the pipeline never sees stale payload.
    always_comb begin
        sel0       = (state == BUSY) && grant_q[0];
        sel1       = (state == BUSY) && grant_q[1];
        mux_tdata  = '0;
        mux_tkeep  = '0;
        mux_tuser  = '0;
        mux_tlast  = 1'b0;
        mux_tvalid = 1'b0;
        if (sel0) begin
            mux_tdata  = s0.tdata;
            mux_tkeep  = s0.tkeep;
            mux_tuser  = s0.tuser;
            mux_tlast  = s0.tlast;
            mux_tvalid = s0.tvalid;
        end else if (sel1) begin
            mux_tdata  = s1.tdata;
            mux_tkeep  = s1.tkeep;
            mux_tuser  = s1.tuser;
            mux_tlast  = s1.tlast;
            mux_tvalid = s1.tvalid;
        end
        s0_ready = sel0 && m.tready;
        s1_ready = sel1 && m.tready;
        hs       = mux_tvalid && m.tready;
    end

    assign m.tdata   = mux_tdata;
    assign m.tkeep   = mux_tkeep;
    assign m.tuser   = mux_tuser;
    assign m.tlast   = mux_tlast;
    assign m.tvalid  = mux_tvalid;
    assign s0.tready = s0_ready;
    assign s1.tready = s1_ready;
    assign grant     = grant_q;

endmodule

// File: tb/tb_pipeline_ingress_arbiter.sv
// ---------------------------------------------------------------------------
// tb_pipeline_ingress_arbiter
//
// Directed, table-driven bench for pipeline_ingress_arbiter. Each vector is
// one clock cycle: inputs are driven just after the rising edge, outputs are
// compared a little later in the same cycle, then the clock advances.
// Counters are built 4 bits wide so the wrap can be reached quickly.
// ---------------------------------------------------------------------------
module tb_pipeline_ingress_arbiter;

    localparam int DATA_W = 512;
    localparam int KEEP_W = 64;
    localparam int USER_W = 48;
    localparam int CNT_W  = 4;

    localparam logic [63:0] KF = 64'hffff_ffff_ffff_ffff;
    localparam logic [63:0] KP = 64'h0000_0007_ffff_ffff;

    typedef struct {
        logic        v;
        logic        l;
        logic [31:0] tag;
        logic [63:0] keep;
        logic [47:0] user;
    } beat_t;

    // src: 0 = nothing routed, 1 = s0 routed to m, 2 = s1 routed to m
    typedef struct {
        logic       rst;
        beat_t      s0;
        beat_t      s1;
        logic       mr;
        int         src;
        logic       r0;
        logic       r1;
        logic [1:0] g;
        logic [3:0] c0;
        logic [3:0] c1;
    } vec_t;

    logic ap_clk;
    logic ap_rst;
    logic [1:0]       grant;
    logic [CNT_W-1:0] pkt_cnt0;
    logic [CNT_W-1:0] pkt_cnt1;

    int checks;
    int errors;
    int vid;

    pipeline_ingress_arbiter_if #(.DATA_W(DATA_W), .KEEP_W(KEEP_W), .USER_W(USER_W)) s0_if ();
    pipeline_ingress_arbiter_if #(.DATA_W(DATA_W), .KEEP_W(KEEP_W), .USER_W(USER_W)) s1_if ();
    pipeline_ingress_arbiter_if #(.DATA_W(DATA_W), .KEEP_W(KEEP_W), .USER_W(USER_W)) m_if ();

    pipeline_ingress_arbiter #(
        .DATA_W(DATA_W),
        .KEEP_W(KEEP_W),
        .USER_W(USER_W),
        .CNT_W (CNT_W)
    ) dut (
        .ap_clk  (ap_clk),
        .ap_rst  (ap_rst),
        .s0      (s0_if),
        .s1      (s1_if),
        .m       (m_if),
        .grant   (grant),
        .pkt_cnt0(pkt_cnt0),
        .pkt_cnt1(pkt_cnt1)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    function automatic beat_t bt(logic v, logic l, logic [31:0] tag, logic [63:0] keep, logic [47:0] user);
        beat_t b;
        b.v    = v;
        b.l    = l;
        b.tag  = tag;
        b.keep = keep;
        b.user = user;
        return b;
    endfunction

    function automatic vec_t mk(logic rst, beat_t s0, beat_t s1, logic mr, int src,
                                logic r0, logic r1, logic [1:0] g, logic [3:0] c0, logic [3:0] c1);
        vec_t v;
        v.rst = rst;
        v.s0  = s0;
        v.s1  = s1;
        v.mr  = mr;
        v.src = src;
        v.r0  = r0;
        v.r1  = r1;
        v.g   = g;
        v.c0  = c0;
        v.c1  = c1;
        return v;
    endfunction

    task automatic check(string name, logic [511:0] act, logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(vec_t v);
        ap_rst         = v.rst;
        s0_if.tvalid   = v.s0.v;
        s0_if.tlast    = v.s0.l;
        s0_if.tdata    = {16{v.s0.tag}};
        s0_if.tkeep    = v.s0.keep;
        s0_if.tuser    = v.s0.user;
        s1_if.tvalid   = v.s1.v;
        s1_if.tlast    = v.s1.l;
        s1_if.tdata    = {16{v.s1.tag}};
        s1_if.tkeep    = v.s1.keep;
        s1_if.tuser    = v.s1.user;
        m_if.tready    = v.mr;
        #1;
    endtask

    task automatic checkOutput(vec_t v);
        beat_t       eb;
        logic [511:0] edata;
        eb = bt(0, 0, 0, 0, 0);
        if (v.src == 1) eb = v.s0;
        if (v.src == 2) eb = v.s1;
        edata = (v.src == 0) ? 512'd0 : {16{eb.tag}};
        check($sformatf("v%0d.m_tvalid", vid), 512'(m_if.tvalid), 512'(eb.v));
        check($sformatf("v%0d.m_tlast", vid), 512'(m_if.tlast), 512'(eb.l));
        check($sformatf("v%0d.m_tdata", vid), m_if.tdata, edata);
        check($sformatf("v%0d.m_tkeep", vid), 512'(m_if.tkeep), 512'(eb.keep));
        check($sformatf("v%0d.m_tuser", vid), 512'(m_if.tuser), 512'(eb.user));
        check($sformatf("v%0d.s0_tready", vid), 512'(s0_if.tready), 512'(v.r0));
        check($sformatf("v%0d.s1_tready", vid), 512'(s1_if.tready), 512'(v.r1));
        check($sformatf("v%0d.grant", vid), 512'(grant), 512'(v.g));
        check($sformatf("v%0d.pkt_cnt0", vid), 512'(pkt_cnt0), 512'(v.c0));
        check($sformatf("v%0d.pkt_cnt1", vid), 512'(pkt_cnt1), 512'(v.c1));
    endtask

    task automatic run(vec_t v);
        applyStimulus(v);
        checkOutput(v);
        @(posedge ap_clk);
        #1;
        vid++;
    endtask

    initial begin
        vec_t  tbl[$];
        beat_t nb, a0, a1, b0, b1, c0, c1, f0, f1, g0, g1, h0;
        beat_t d[3];
        beat_t e[3];

        checks = 0;
        errors = 0;
        vid    = 0;

        nb = bt(0, 0, 32'h0, 64'h0, 48'h0);
        a0 = bt(1, 0, 32'hA0A0_0000, KF, 48'h62);
        a1 = bt(1, 1, 32'hA0A0_0001, KP, 48'h62);
        b0 = bt(1, 0, 32'hB0B0_0000, KF, 48'h62);
        b1 = bt(1, 1, 32'hB0B0_0001, KP, 48'h62);
        c0 = bt(1, 0, 32'hC0C0_0000, KF, 48'h46);
        c1 = bt(1, 1, 32'hC0C0_0001, 64'h3f, 48'h46);
        for (int k = 0; k < 3; k++) begin
            d[k] = bt(1, 1, 32'hD0D0_0000 + k, KF, 48'h40);
            e[k] = bt(1, 1, 32'hE0E0_0000 + k, KF, 48'h41);
        end
        f0 = bt(1, 0, 32'hF0F0_0000, KF, 48'h80);
        f1 = bt(1, 1, 32'hF0F0_0001, 64'hff, 48'h80);
        g0 = bt(1, 0, 32'h9090_0000, KF, 48'h55);
        g1 = bt(1, 1, 32'h9090_0001, KF, 48'h55);
        h0 = bt(1, 1, 32'h7070_0000, KF, 48'h33);

        // single 2-beat packet on s0
        tbl.push_back(mk(1, a0, nb, 1, 0, 0, 0, 2'b00, 0, 0));
        tbl.push_back(mk(0, a0, nb, 1, 0, 0, 0, 2'b00, 0, 0));
        tbl.push_back(mk(0, a0, nb, 1, 1, 1, 0, 2'b01, 0, 0));
        tbl.push_back(mk(0, a1, nb, 1, 1, 1, 0, 2'b01, 0, 0));
        tbl.push_back(mk(0, nb, nb, 1, 0, 0, 0, 2'b00, 1, 0));
        // simultaneous requests straight after reset: s0 first, bubble, s1
        tbl.push_back(mk(1, b0, c0, 1, 0, 0, 0, 2'b00, 1, 0));
        tbl.push_back(mk(0, b0, c0, 1, 0, 0, 0, 2'b00, 0, 0));
        tbl.push_back(mk(0, b0, c0, 1, 1, 1, 0, 2'b01, 0, 0));
        tbl.push_back(mk(0, b1, c0, 1, 1, 1, 0, 2'b01, 0, 0));
        tbl.push_back(mk(0, nb, c0, 1, 0, 0, 0, 2'b00, 1, 0));
        tbl.push_back(mk(0, nb, c0, 1, 2, 0, 1, 2'b10, 1, 0));
        tbl.push_back(mk(0, nb, c1, 1, 2, 0, 1, 2'b10, 1, 0));
        tbl.push_back(mk(0, nb, nb, 1, 0, 0, 0, 2'b00, 1, 1));
        // continuous contention, three single-beat packets per source
        tbl.push_back(mk(1, d[0], e[0], 1, 0, 0, 0, 2'b00, 1, 1));
        tbl.push_back(mk(0, d[0], e[0], 1, 0, 0, 0, 2'b00, 0, 0));
        tbl.push_back(mk(0, d[0], e[0], 1, 1, 1, 0, 2'b01, 0, 0));
        tbl.push_back(mk(0, d[1], e[0], 1, 0, 0, 0, 2'b00, 1, 0));
        tbl.push_back(mk(0, d[1], e[0], 1, 2, 0, 1, 2'b10, 1, 0));
        tbl.push_back(mk(0, d[1], e[1], 1, 0, 0, 0, 2'b00, 1, 1));
        tbl.push_back(mk(0, d[1], e[1], 1, 1, 1, 0, 2'b01, 1, 1));
        tbl.push_back(mk(0, d[2], e[1], 1, 0, 0, 0, 2'b00, 2, 1));
        tbl.push_back(mk(0, d[2], e[1], 1, 2, 0, 1, 2'b10, 2, 1));
        tbl.push_back(mk(0, d[2], e[2], 1, 0, 0, 0, 2'b00, 2, 2));
        tbl.push_back(mk(0, d[2], e[2], 1, 1, 1, 0, 2'b01, 2, 2));
        tbl.push_back(mk(0, nb, e[2], 1, 0, 0, 0, 2'b00, 3, 2));
        tbl.push_back(mk(0, nb, e[2], 1, 2, 0, 1, 2'b10, 3, 2));
        tbl.push_back(mk(0, nb, nb, 1, 0, 0, 0, 2'b00, 3, 3));
        // backpressure for 5 cycles on beat 2 of an s1 packet
        tbl.push_back(mk(0, nb, f0, 1, 0, 0, 0, 2'b00, 3, 3));
        tbl.push_back(mk(0, nb, f0, 1, 2, 0, 1, 2'b10, 3, 3));
        for (int k = 0; k < 5; k++) begin
            tbl.push_back(mk(0, nb, f1, 0, 2, 0, 0, 2'b10, 3, 3));
        end
        tbl.push_back(mk(0, nb, f1, 1, 2, 0, 1, 2'b10, 3, 3));
        tbl.push_back(mk(0, nb, nb, 1, 0, 0, 0, 2'b00, 3, 4));

        // bring the DUT out of its power-up state before the first vector
        applyStimulus(mk(1, nb, nb, 0, 0, 0, 0, 2'b00, 0, 0));
        @(posedge ap_clk);
        #1;

        for (int i = 0; i < tbl.size(); i++) begin
            run(tbl[i]);
        end

        // counter wrap: 17 single-beat packets on s0 with a 4-bit counter
        $display("[TB] counter wrap sequence");
        run(mk(1, nb, nb, 1, 0, 0, 0, 2'b00, 3, 4));
        for (int k = 0; k < 17; k++) begin
            beat_t     p;
            logic [3:0] c;
            p = bt(1, 1, 32'h5A00_0000 + k, KF, 48'(k + 1));
            c = 4'(k);
            run(mk(0, p, nb, 1, 0, 0, 0, 2'b00, c, 0));
            run(mk(0, p, nb, 1, 1, 1, 0, 2'b01, c, 0));
        end
        run(mk(0, nb, nb, 1, 0, 0, 0, 2'b00, 1, 0));

        // reset in the middle of a 2-beat s0 packet, then a normal s1 grant
        $display("[TB] reset mid-packet sequence");
        run(mk(0, g0, nb, 1, 0, 0, 0, 2'b00, 1, 0));
        run(mk(0, g0, nb, 1, 1, 1, 0, 2'b01, 1, 0));
        run(mk(1, g1, nb, 1, 1, 1, 0, 2'b01, 1, 0));
        run(mk(0, nb, h0, 1, 0, 0, 0, 2'b00, 0, 0));
        run(mk(0, nb, h0, 1, 2, 0, 1, 2'b10, 0, 0));
        run(mk(0, nb, nb, 1, 0, 0, 0, 2'b00, 0, 1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_ingress_arbiter.md
Name: pipeline_ingress_arbiter

Overview:
- Packet-atomic round-robin arbiter for the Nanotube pipeline ingress port (512-bit AXI-Stream, 64-bit tkeep, 48-bit tuser).
- Shares the single pipeline port between two upstream AXI-Stream requesters (s0, s1), for example a host queue and a MAC queue.
- A grant is held for a whole packet, until the tlast handshake, so beats from different packets never interleave.
- Keeps a wrapping per-source packet counter for debug and statistics.

Parameters:
- DATA_W, 512, tdata width.
- KEEP_W, 64, tkeep width (DATA_W/8).
- USER_W, 48, tuser width (carries packet length in the low bits; passed through unmodified).
- CNT_W, 32, width of each per-source packet counter.

Ports:
- ap_clk  in  1  single clock, rising edge.
- ap_rst  in  1  synchronous, active-high reset.
- s0_tdata/s0_tkeep/s0_tuser/s0_tlast/s0_tvalid  in  DATA_W/KEEP_W/USER_W/1/1  requester 0 stream.
- s0_tready  out  1  requester 0 ready.
- s1_tdata/s1_tkeep/s1_tuser/s1_tlast/s1_tvalid  in  DATA_W/KEEP_W/USER_W/1/1  requester 1 stream.
- s1_tready  out  1  requester 1 ready.
- m_tdata/m_tkeep/m_tuser/m_tlast/m_tvalid  out  DATA_W/KEEP_W/USER_W/1/1  to pipeline port0.
- m_tready  in  1  pipeline ready.
- grant  out  2  one-hot active grant; 00 when idle.
- pkt_cnt0  out  CNT_W  packets completed from s0.
- pkt_cnt1  out  CNT_W  packets completed from s1.

Behaviour:
- Reset (ap_rst=1 at a rising edge):
  - state=IDLE, grant=00, last_grant=s1 (so s0 wins the first tie).
  - pkt_cnt0=pkt_cnt1=0.
  - m_tvalid=0, s0_tready=s1_tready=0.
  - m_tdata/m_tkeep/m_tuser/m_tlast driven to 0 while idle.
- State IDLE:
  - All treadys are 0 and m_tvalid=0.
  - If exactly one s*_tvalid=1: grant that source and go to BUSY.
  - If both are valid: grant the source that is not last_grant and go to BUSY.
  - If neither is valid: stay in IDLE.
  - The decision is registered, so the first beat reaches m_* one cycle after the request is seen in IDLE.
- State BUSY(g):
  - m_* = s_g_* (combinational mux on the registered grant).
  - s_g_tready = m_tready; the non-granted tready = 0.
  - Beat transfer happens on m_tvalid & m_tready.
  - A handshake with tlast=1: pkt_cnt_g += 1 (wraps modulo 2^CNT_W), last_grant=g, next state IDLE, grant=00.
  - A handshake with tlast=0: stay in BUSY(g).
  - s_g_tvalid dropping mid-packet: stay in BUSY(g) with m_tvalid=0; the grant is never released before tlast.
- Cost: one idle cycle between consecutive packets (arbitration bubble); there are no back-to-back grants.
- Single-beat packets (tlast on the first beat) are legal: BUSY lasts one handshake, then IDLE.
- m_tready=0: the granted source sees tready=0 and its data is held by the source, per AXI-S rules. The arbiter stores no data.
- A requester that drops tvalid while in IDLE before being granted loses nothing, because no handshake occurred.
- Reset mid-packet: return to IDLE immediately and clear counters. The partial packet is truncated at the output. Upstream is responsible for flushing it.
- The grant pointer updates only on packet completion. Starvation-free: with both sources continuously valid, grants alternate s0, s1, s0, ...

Test Plan:
- Single packet on s0: 2 beats, tuser=48'h62, beat-2 tkeep=64'h00000007ffffffff, m_tready=1. Required: m_* matches s0 beat-for-beat starting one cycle after s0_tvalid; grant=01 during the packet, 00 after; pkt_cnt0=1, pkt_cnt1=0.
- Simultaneous requests after reset: s0 sends tuser=0x62, s1 sends tuser=0x46, both 2 beats and valid on the same cycle. Required: s0 packet first, one idle cycle, then s1 packet. No interleaving; s1_tready=0 throughout the s0 packet. Counts end at 1/1.
- Continuous contention: 3 packets queued on each source. Required: output order s0, s1, s0, s1, s0, s1; pkt_cnt0=pkt_cnt1=3.
- Backpressure: m_tready=0 for 5 cycles during beat 2 of an s1 packet. Required: m_tvalid=1 and m_tdata held stable; s1_tready=0 throughout; counter increments only on the final handshake.
- Counter wrap with CNT_W=4: send 17 single-beat packets on s0. Required: pkt_cnt0 sequence 1..15, 0, 1.
- Reset mid-packet: assert ap_rst for one cycle after beat 1 of a 2-beat s0 packet. Required: next cycle grant=00, m_tvalid=0, counters 0. The following s1 request is granted normally, one cycle after it is seen.
